// File: rtl/darkroom_spi_frame_receiver.sv
// SPI slave receiving 256-bit DarkRoom sensor frames into a per-frame buffer.
// Committed frames are read back over an Avalon-MM slave using DarkRoom's map.
module darkroom_spi_frame_receiver #(
  parameter int NUMBER_OF_SENSORS = 8,
  parameter int GAP_TIMEOUT       = 2048
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sck_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  input  logic [6:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        frame_done_o,
  output logic [3:0]  frame_index_o,
  output logic [7:0]  error_count_o
);

  localparam int NF = (NUMBER_OF_SENSORS + 7) / 8;
  localparam int GW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, COMMIT} state_t;

  logic [2:0]   sck_q, ss_q;
  logic [1:0]   mosi_q;
  state_t       state_q, state_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   bit_q, bit_d;
  logic [5:0]   byte_q, byte_d;
  logic         ovf_q, ovf_d;
  logic [255:0] stage_q, stage_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   last_q, last_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]   err_q, err_d;
  logic [255:0] buf_q [NF];
  logic [255:0] buf_d [NF];
  logic [31:0]  rdata_q, rdata_d;
  logic         wr_q, wr_d;

  logic ss_s, ss_fall, ss_rise, sck_rise, mosi_s;
  logic [7:0] byte_in;

  assign ss_s     = ss_q[1];
  assign ss_fall  = ss_q[2] & ~ss_q[1];
  assign ss_rise  = ~ss_q[2] & ss_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign mosi_s   = mosi_q[1];
  assign byte_in  = {shift_q[6:0], mosi_s};

  // Two-flop synchronisers plus an edge-detect stage; ss resets low so a
  // select held low across reset release is not mistaken for a fresh fall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_q  <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck_i};
      ss_q   <= {ss_q[1:0], ss_n_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  // Frame FSM: assembly, length check, commit and gap-driven index reset.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    ovf_d   = ovf_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gap_d   = gap_q;
    err_d   = err_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (ss_s && gap_q != GW'(GAP_TIMEOUT))
          gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_TIMEOUT))
          idx_d = '0;
        if (ss_fall) begin
          state_d = RECEIVE;
          bit_d   = '0;
          byte_d  = '0;
          ovf_d   = 1'b0;
          shift_d = '0;
        end
      end
      RECEIVE: begin
        if (ss_rise) begin
          if (byte_q == 6'd32 && bit_q == 3'd0 && !ovf_q) begin
            state_d = COMMIT;
          end else begin
            state_d = IDLE;
            if (err_q != 8'hFF)
              err_d = err_q + 1'b1;
          end
        end else if (sck_rise && !ss_s) begin
          shift_d = byte_in;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            if (byte_q == 6'd32) begin
              ovf_d = 1'b1;
            end else begin
              stage_d[{byte_q[4:0], 3'b000} +: 8] = byte_in;
              byte_d = byte_q + 1'b1;
            end
          end
        end
      end
      COMMIT: begin
        for (int f = 0; f < NF; f++)
          if (idx_q == 4'(f))
            buf_d[f] = stage_q;
        last_d  = idx_q;
        idx_d   = (idx_q == 4'(NF - 1)) ? 4'd0 : idx_q + 1'b1;
        gap_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Avalon read: capture on the accepting edge, one cycle of waitrequest.
  always_comb begin
    rdata_d = rdata_q;
    wr_d    = read & ~wr_q;
    if (read && !wr_q) begin
      rdata_d = '0;
      for (int f = 0; f < NF; f++)
        if (address[6:3] == 4'(f))
          rdata_d = buf_q[f][{address[2:0], 5'b00000} +: 32];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      ovf_q   <= 1'b0;
      stage_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      gap_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      for (int f = 0; f < NF; f++)
        buf_q[f] <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      ovf_q   <= ovf_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      for (int f = 0; f < NF; f++)
        buf_q[f] <= buf_d[f];
    end
  end

  assign frame_done_o  = (state_q == COMMIT);
  assign frame_index_o = last_q;
  assign error_count_o = err_q;
  assign readdata      = rdata_q;
  assign waitrequest   = wr_q;

endmodule
